// File: rtl/m_counter_seq.sv
// m_counter_seq: job sequencer driving one up/down counter through S/EN/IN/OUT.
// Macro M_COUNTER_SEQ_PRESCALE_EN adds a DIV input and a prescaler that slows counting.
module m_counter_seq #(
  parameter int WIDTH = 8,
  parameter int RPT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef M_COUNTER_SEQ_PRESCALE_EN
  input  logic [7:0]       div,
`endif
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] end_val,
  input  logic [RPT_W-1:0] repeat_n,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [RPT_W-1:0] pass_cnt,
  output logic [1:0]       cnt_s,
  output logic             cnt_en,
  output logic [WIDTH-1:0] cnt_in,
  input  logic [WIDTH-1:0] cnt_out
);
  typedef enum logic [1:0] {INIT, IDLE, LOAD, COUNT} state_t;
  state_t state_q, state_d;
  logic dir_q, dir_d, done_q, done_d;
  logic [WIDTH-1:0] start_q, start_d, end_q, end_d;
  logic [RPT_W-1:0] rep_q, rep_d, pass_q, pass_d;
  logic tick, term;
`ifdef M_COUNTER_SEQ_PRESCALE_EN
  logic [7:0] div_q, div_d, pre_q, pre_d;
  assign tick = (pre_q == div_q);
`else
  assign tick = 1'b1;
`endif
  assign term     = (state_q == COUNT) && (cnt_out == end_q);
  assign ready    = (state_q == IDLE);
  assign busy     = (state_q == LOAD) || (state_q == COUNT);
  assign done     = done_q;
  assign pass_cnt = pass_q;
  assign cnt_in   = start_q;
  assign cnt_s    = (state_q == INIT) ? 2'b00 :
                    (state_q == IDLE) ? 2'b11 :
                    (state_q == LOAD) ? 2'b10 :
                    (dir_q ? 2'b11 : 2'b01);
  // abort must silence the counter in the very cycle it is raised
  assign cnt_en   = (state_q == COUNT) && !abort && tick && (cnt_out != end_q);
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    start_d = start_q;
    end_d   = end_q;
    rep_d   = rep_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
`ifdef M_COUNTER_SEQ_PRESCALE_EN
    div_d   = div_q;
    pre_d   = tick ? 8'd0 : pre_q + 8'd1;
`endif
    if (state_q == INIT) state_d = IDLE;
    else if (state_q == IDLE) begin
      if (start && !abort) begin
        state_d = LOAD;
        dir_d   = dir;
        start_d = start_val;
        end_d   = end_val;
        rep_d   = repeat_n;
        pass_d  = '0;
`ifdef M_COUNTER_SEQ_PRESCALE_EN
        div_d   = div;
`endif
      end
    end
    else if (abort) state_d = IDLE;
    else if (state_q == LOAD) begin
      state_d = COUNT;
`ifdef M_COUNTER_SEQ_PRESCALE_EN
      pre_d   = 8'd0;
`endif
    end
    else if (term) begin
      if (pass_q == rep_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = LOAD;
        pass_d  = pass_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      dir_q   <= 1'b0;
      start_q <= '0;
      end_q   <= '0;
      rep_q   <= '0;
      pass_q  <= '0;
      done_q  <= 1'b0;
`ifdef M_COUNTER_SEQ_PRESCALE_EN
      div_q   <= '0;
      pre_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      start_q <= start_d;
      end_q   <= end_d;
      rep_q   <= rep_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
`ifdef M_COUNTER_SEQ_PRESCALE_EN
      div_q   <= div_d;
      pre_q   <= pre_d;
`endif
    end
  end
endmodule
